divider_part2_3: RTL and testbench

//   Programmable 8-bit clock divider built as two cascaded 4-bit up/down nibble counters.
//   The counters load a preset value, count on every clk edge and reload automatically at

---
 rtl/divider_part2_3.sv | 79 +++++++
 tb/tb_divider_part2_3.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/divider_part2_3.sv
// divider_part2_3: programmable 8-bit clock divider made of two cascaded
// 4-bit up/down nibble counters with preset load and auto-reload at
// terminal count.
// Optional feature macro: DIV_SQUARE_OUT_EN
//   defined   -> out is a toggle register flipped on each terminal count
//   undefined -> out is a direct copy of outCo
module divider_part2_3 #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_lo,
  input  logic [3:0] d_hi,
  input  logic       dn,
  input  logic       preset,
  output logic [7:0] q,
  output logic       out,
  output logic       outCo
);

  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] lo_nxt;
  logic [3:0] hi_nxt;
  logic       terminal;

  assign q = {hi, lo};

  // Terminal count: all ones going up, all zeros going down; qualified by
  // an inactive load and inactive reset.
  always_comb begin
    terminal = 1'b0;
    if (preset && !rst) begin
      if (dn) terminal = (hi == 4'hF) && (lo == 4'hF);
      else    terminal = (hi == 4'h0) && (lo == 4'h0);
    end
  end

  assign outCo = terminal;

  // Next count: load on preset low or terminal, otherwise step the low
  // nibble and carry/borrow into the high nibble.
  always_comb begin
    lo_nxt = lo;
    hi_nxt = hi;
    if (!preset || terminal) begin
      lo_nxt = d_lo;
      hi_nxt = d_hi;
    end else if (dn) begin
      lo_nxt = lo + 4'd1;
      if (lo == 4'hF) hi_nxt = hi + 4'd1;
    end else begin
      lo_nxt = lo - 4'd1;
      if (lo == 4'h0) hi_nxt = hi - 4'd1;
    end
  end

  // Count register with asynchronous reset to RESET_VALUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo <= RESET_VALUE[3:0];
      hi <= RESET_VALUE[7:4];
    end else begin
      lo <= lo_nxt;
      hi <= hi_nxt;
    end
  end

`ifdef DIV_SQUARE_OUT_EN
  // Square-wave output: invert on every edge that sees terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           out <= 1'b0;
    else if (terminal) out <= ~out;
  end
`else
  assign out = terminal;
`endif

endmodule

// File: tb/tb_divider_part2_3.sv
// tb_divider_part2_3: directed, table-driven self-checking bench for
// divider_part2_3, plus hand-written multi-cycle sequences.
module tb_divider_part2_3;

  logic       clk;
  logic       rst;
  logic [3:0] d_lo;
  logic [3:0] d_hi;
  logic       dn;
  logic       preset;
  logic [7:0] q;
  logic       out;
  logic       outCo;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        exp_out = 1'b0;

  divider_part2_3 #(.RESET_VALUE(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .d_lo   (d_lo),
    .d_hi   (d_hi),
    .dn     (dn),
    .preset (preset),
    .q      (q),
    .out    (out),
    .outCo  (outCo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       preset;
    logic       dn;
    logic [7:0] d;
    logic       exp_co;  // outCo before the edge
    logic [7:0] exp_q;   // q after the edge
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, check combinational outputs, clock once, check q.
  task automatic step(input logic p, input logic d_n, input logic [7:0] d,
                      input logic exp_co, input logic [7:0] exp_q, input string name);
    preset = p;
    dn     = d_n;
    {d_hi, d_lo} = d;
    #1;
    check({name, ".outCo"}, {7'd0, outCo}, {7'd0, exp_co});
`ifdef DIV_SQUARE_OUT_EN
    check({name, ".out"}, {7'd0, out}, {7'd0, exp_out});
`else
    check({name, ".out"}, {7'd0, out}, {7'd0, exp_co});
`endif
    @(posedge clk);
    if (exp_co) exp_out = ~exp_out;
    #1;
    check({name, ".q"}, q, exp_q);
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      // load 05, count down 05..00, reload
      '{1'b0, 1'b0, 8'h05, 1'b0, 8'h05},
      '{1'b1, 1'b0, 8'h05, 1'b0, 8'h04},
      '{1'b1, 1'b0, 8'h05, 1'b0, 8'h03},
      '{1'b1, 1'b0, 8'h05, 1'b0, 8'h02},
      '{1'b1, 1'b0, 8'h05, 1'b0, 8'h01},
      '{1'b1, 1'b0, 8'h05, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h05, 1'b1, 8'h05},
      '{1'b1, 1'b0, 8'h05, 1'b0, 8'h04},
      // load C3, then preset pulse with D=99
      '{1'b0, 1'b1, 8'hC3, 1'b0, 8'hC3},
      '{1'b0, 1'b1, 8'h99, 1'b0, 8'h99},
      '{1'b1, 1'b1, 8'h99, 1'b0, 8'h9A},
      // direction change mid-count
      '{1'b1, 1'b0, 8'h99, 1'b0, 8'h99},
      '{1'b1, 1'b0, 8'h99, 1'b0, 8'h98},
      // nibble borrow and carry
      '{1'b0, 1'b0, 8'h10, 1'b0, 8'h10},
      '{1'b1, 1'b0, 8'h10, 1'b0, 8'h0F},
      '{1'b1, 1'b1, 8'h10, 1'b0, 8'h10},
      // D=FF up: stuck terminal
      '{1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF},
      '{1'b1, 1'b1, 8'hFF, 1'b1, 8'hFF},
      // reload samples D on the terminal edge
      '{1'b1, 1'b1, 8'h20, 1'b1, 8'h20},
      '{1'b1, 1'b0, 8'h20, 1'b0, 8'h1F},
      '{1'b1, 1'b1, 8'h20, 1'b0, 8'h20},
      // D=00 down: stuck terminal; dn flip leaves terminal at once
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00},
      '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00},
      '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00},
      '{1'b1, 1'b1, 8'h00, 1'b0, 8'h01}
    };

    // Reset with clock running and preset toggling.
    rst = 1'b1;
    preset = 1'b0;
    dn = 1'b1;
    {d_hi, d_lo} = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      preset = i[0];
      #1;
      check("reset.q", q, 8'h00);
      check("reset.out", {7'd0, out}, 8'h00);
      check("reset.outCo", {7'd0, outCo}, 8'h00);
    end
    exp_out = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].preset, vecs[i].dn, vecs[i].d, vecs[i].exp_co, vecs[i].exp_q,
           $sformatf("vec%0d", i));
    end

    // D=99 up: terminal once every 103 clocks, two full periods.
    step(1'b0, 1'b1, 8'h99, 1'b0, 8'h99, "up99.load");
    for (int k = 0; k < 2 * 103; k++) begin
      automatic logic [7:0] cur = 8'h99 + 8'(k % 103);
      automatic logic       co  = (cur == 8'hFF);
      automatic logic [7:0] nxt = co ? 8'h99 : cur + 8'd1;
      step(1'b1, 1'b1, 8'h99, co, nxt, $sformatf("up99.%0d", k));
    end

    // Asynchronous reset mid-count at q=E0.
    step(1'b0, 1'b1, 8'hE0, 1'b0, 8'hE0, "midrst.load");
    preset = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    exp_out = 1'b0;
    check("midrst.q", q, 8'h00);
    check("midrst.out", {7'd0, out}, 8'h00);
    check("midrst.outCo", {7'd0, outCo}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 257; k++) begin
      automatic logic [7:0] cur = 8'(k);
      automatic logic       co  = (k == 255);
      automatic logic [7:0] nxt = co ? 8'h99 : cur + 8'd1;
      step(1'b1, 1'b1, 8'h99, co, (k == 256) ? 8'h9A : nxt, $sformatf("afterrst.%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
